// File: rtl/song_sequencer_if.sv
// Bundles the sequencer's control inputs, ROM port and note-player outputs.
// master = sequencer side, slave = environment (control, ROM, note player).
interface song_sequencer_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          beat;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]       rom_dout;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          new_note;
  logic                          playing;
  logic                          song_done;

  modport master (
    input  play, song, beat, rom_dout,
    output rom_addr, note, duration, new_note, playing, song_done
  );

  modport slave (
    output play, song, beat, rom_dout,
    input  rom_addr, note, duration, new_note, playing, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song playback controller: walks one 32-entry song of the note ROM, issues
// each note with a one-cycle new_note strobe and holds it for its duration
// in beats. Supports pause (play=0), song change and end-of-song detection.
module song_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  song_sequencer_if.master  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] PLAY  = 2'd3;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  logic [1:0]                    state_reg;
  logic [IDX_BITS-1:0]           idx_reg;
  logic [SONG_BITS-1:0]          song_reg;
  logic [DUR_W-1:0]              beat_cnt_reg;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr_reg;
  logic [NOTE_W-1:0]             note_reg;
  logic [DUR_W-1:0]              duration_reg;
  logic                          new_note_reg;
  logic                          song_done_reg;

  logic [NOTE_W-1:0]   dout_note;
  logic [DUR_W-1:0]    dout_dur;
  logic [IDX_BITS-1:0] idx_inc;
  logic                song_change;
  logic                beat_taken;

  assign dout_dur    = bus.rom_dout[DUR_W-1:0];
  assign dout_note   = bus.rom_dout[NOTE_W+DUR_W-1:DUR_W];
  assign idx_inc     = idx_reg + IDX_BITS'(1);
  // A different song select restarts playback from any active state.
  assign song_change = (state_reg != IDLE) && (bus.song != song_reg);
  // Beats only count while holding a note and not paused.
  assign beat_taken  = bus.beat && bus.play;

  // Sequencer state, ROM address, current note and one-cycle strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      song_reg      <= '0;
      beat_cnt_reg  <= '0;
      rom_addr_reg  <= '0;
      note_reg      <= '0;
      duration_reg  <= '0;
      new_note_reg  <= 1'b0;
      song_done_reg <= 1'b0;
    end else begin
      new_note_reg  <= 1'b0;
      song_done_reg <= 1'b0;
      if (song_change) begin
        // Takes priority over note completion and the WAIT decode.
        song_reg     <= bus.song;
        idx_reg      <= '0;
        rom_addr_reg <= {bus.song, {IDX_BITS{1'b0}}};
        state_reg    <= FETCH;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.play) begin
              song_reg     <= bus.song;
              idx_reg      <= '0;
              rom_addr_reg <= {bus.song, {IDX_BITS{1'b0}}};
              state_reg    <= FETCH;
            end
          end
          FETCH: begin
            // ROM samples rom_addr on this edge; data is valid in WAIT.
            state_reg <= WAIT;
          end
          WAIT: begin
            if (dout_dur == '0) begin
              // End marker: note/duration keep their last values.
              song_done_reg <= 1'b1;
              idx_reg       <= '0;
              state_reg     <= IDLE;
            end else begin
              note_reg      <= dout_note;
              duration_reg  <= dout_dur;
              beat_cnt_reg  <= dout_dur;
              new_note_reg  <= 1'b1;
              state_reg     <= PLAY;
            end
          end
          PLAY: begin
            if (beat_taken) begin
              if (beat_cnt_reg > DUR_W'(1)) begin
                beat_cnt_reg <= beat_cnt_reg - DUR_W'(1);
              end else if (idx_reg == LAST_IDX) begin
                // Last slot of the song: stop rather than run into the next song.
                song_done_reg <= 1'b1;
                idx_reg       <= '0;
                state_reg     <= IDLE;
              end else begin
                idx_reg      <= idx_inc;
                rom_addr_reg <= {song_reg, idx_inc};
                state_reg    <= FETCH;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr  = rom_addr_reg;
  assign bus.note      = note_reg;
  assign bus.duration  = duration_reg;
  assign bus.new_note  = new_note_reg;
  assign bus.song_done = song_done_reg;
  assign bus.playing   = (state_reg != IDLE);
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural playback model.
module tb_song_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  song_sequencer_if bus ();

  song_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Song ROM with one cycle of registered read latency.
  logic [11:0] rom [128];
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  bit         m_active;
  logic [1:0] m_song;
  logic [4:0] m_idx;
  int         m_left;   // beats remaining on current note
  int         m_fetch;  // cycles until the pending entry is decoded (0 = holding a note)
  logic [6:0] e_addr;
  logic [5:0] e_note, e_dur;
  bit         e_new, e_done;

  function automatic void model_reset();
    m_active = 0; m_song = 0; m_idx = 0; m_left = 0; m_fetch = 0;
    e_addr = 0; e_note = 0; e_dur = 0; e_new = 0; e_done = 0;
  endfunction

  function automatic void start_song(logic [1:0] s);
    m_song = s; m_idx = 0; e_addr = {s, 5'd0}; m_fetch = 2;
  endfunction

  function automatic void model_step(bit p, logic [1:0] s, bit b);
    logic [11:0] ent;
    e_new = 0; e_done = 0;
    if (!m_active) begin
      if (p) begin m_active = 1; start_song(s); end
    end else if (s != m_song) begin
      start_song(s);
    end else if (m_fetch == 2) begin
      m_fetch = 1;
    end else if (m_fetch == 1) begin
      ent = rom[{m_song, m_idx}];
      if (ent[5:0] == 0) begin
        e_done = 1; m_active = 0; m_idx = 0;
      end else begin
        e_note = ent[11:6]; e_dur = ent[5:0]; m_left = int'(ent[5:0]);
        e_new = 1; m_fetch = 0;
      end
    end else if (p && b) begin
      if (m_left > 1) m_left--;
      else if (m_idx == 31) begin e_done = 1; m_active = 0; m_idx = 0; end
      else begin m_idx++; e_addr = {m_song, m_idx}; m_fetch = 2; end
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    checks++;
    if (bus.rom_addr !== e_addr || bus.note !== e_note || bus.duration !== e_dur ||
        bus.new_note !== e_new || bus.playing !== m_active || bus.song_done !== e_done) begin
      errors++;
      $display("FAIL outputs t=%0t got/exp addr %0d/%0d note %0d/%0d dur %0d/%0d new %0b/%0b playing %0b/%0b done %0b/%0b",
               $time, bus.rom_addr, e_addr, bus.note, e_note, bus.duration, e_dur,
               bus.new_note, e_new, bus.playing, m_active, bus.song_done, e_done);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit p, input logic [1:0] s, input bit b);
    bus.play = p; bus.song = s; bus.beat = b;
    @(posedge clk);
    if (reset_n) model_step(p, s, b);
    #2;
  endtask

  int cyc = 0;
  bit last_b;
  // Fixed beat every 4 cycles; last_b records a beat taken with play=1.
  task automatic tstep(input bit p, input logic [1:0] s);
    bit b;
    b = (cyc % 4 == 0);
    cyc++;
    last_b = b && p;
    step(p, s, b);
  endtask

  task automatic wait_new(input bit p, input logic [1:0] s, input string name, output int n);
    bit seen;
    seen = 0; n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tstep(p, s); n++;
      if (bus.new_note) seen = 1;
    end
    chk({name, "_seen"}, int'(seen), 1);
  endtask

  initial begin
    int n, nb, nnew;
    bit seen, hit64;
    logic [1:0] s;
    int bcnt;
    bit p;
    logic [1:0] rs;

    for (int i = 0; i < 128; i++) begin
      rom[i][11:6] = 6'($urandom);
      rom[i][5:0]  = 6'($urandom_range(1, 3));
      if (i >= 64 && (i % 32) != 0 && $urandom_range(0, 7) == 0) rom[i][5:0] = 6'd0;
    end
    rom[0] = {6'd49, 6'd12};
    rom[1] = {6'd1, 6'd8};
    rom[2] = {6'd5, 6'd3};
    rom[3] = {6'd0, 6'd0};
    rom[64] = {6'd33, 6'd2};

    model_reset();
    bus.play = 0; bus.song = 0; bus.beat = 0;
    step(0, 0, 0); step(0, 0, 0);
    chk("reset_addr", int'(bus.rom_addr), 0);
    chk("reset_playing", int'(bus.playing), 0);
    chk("reset_note", int'(bus.note), 0);
    reset_n = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    chk("idle_no_play", int'(bus.playing), 0);

    // First note: latency and fields.
    wait_new(1, 0, "first_note", n);
    chk("first_latency", n, 3);
    chk("first_note", int'(bus.note), 49);
    chk("first_dur", int'(bus.duration), 12);
    chk("first_addr", int'(bus.rom_addr), 0);

    // 4 beats, pause for 5 beat periods, then expect 8 more beats to end the note.
    nb = 0;
    for (int i = 0; i < 100 && nb < 4; i++) begin tstep(1, 0); if (last_b) nb++; end
    for (int i = 0; i < 20; i++) tstep(0, 0);
    chk("pause_addr", int'(bus.rom_addr), 0);
    chk("pause_playing", int'(bus.playing), 1);
    nb = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tstep(1, 0); if (last_b) nb++;
      if (bus.rom_addr == 7'd1) seen = 1;
    end
    chk("resume_beats", nb, 8);
    wait_new(1, 0, "second_note", n);
    chk("gap_latency", n, 2);
    chk("second_note", int'(bus.note), 1);
    chk("second_dur", int'(bus.duration), 8);

    // Entry 2 plays, entry 3 is the end marker.
    seen = 0; nnew = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tstep(1, 0);
      if (bus.new_note) nnew++;
      if (bus.song_done) seen = 1;
    end
    chk("end_done_seen", int'(seen), 1);
    chk("end_new_count", nnew, 1);
    chk("end_done_no_new", int'(bus.new_note), 0);
    chk("end_playing", int'(bus.playing), 0);
    chk("end_addr", int'(bus.rom_addr), 3);
    chk("end_note_held", int'(bus.note), 5);
    for (int i = 0; i < 4; i++) tstep(0, 0);

    // Song change to 2 on the final beat of entry 0.
    wait_new(1, 0, "chg_first", n);
    nb = 0; s = 0; seen = 0;
    for (int i = 0; i < 200 && s == 0; i++) begin
      if ((cyc % 4 == 0) && nb == 11) s = 2;
      tstep(1, s);
      if (last_b) nb++;
      if (bus.song_done) seen = 1;
    end
    chk("chg_addr", int'(bus.rom_addr), 64);
    chk("chg_no_done", int'(seen), 0);
    wait_new(1, 2, "chg_note", n);
    chk("chg_note_val", int'(bus.note), 33);
    chk("chg_dur_val", int'(bus.duration), 2);

    // Song 1: all 32 entries non-zero, must stop after idx 31.
    seen = 0; nnew = 0; hit64 = 0;
    tstep(1, 1);
    for (int i = 0; i < 3000 && !seen; i++) begin
      tstep(1, 1);
      if (bus.new_note) nnew++;
      if (bus.rom_addr >= 7'd64) hit64 = 1;
      if (bus.song_done) seen = 1;
    end
    chk("song1_done_seen", int'(seen), 1);
    chk("song1_notes", nnew, 32);
    chk("song1_no_wrap", int'(hit64), 0);
    chk("song1_last_addr", int'(bus.rom_addr), 63);
    for (int i = 0; i < 4; i++) tstep(0, 1);

    // Asynchronous reset mid-note, then restart on song 2.
    wait_new(1, 3, "rst_note", n);
    tstep(1, 3); tstep(1, 3);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_addr", int'(bus.rom_addr), 0);
    chk("async_rst_note", int'(bus.note), 0);
    chk("async_rst_playing", int'(bus.playing), 0);
    tstep(1, 2); tstep(1, 2);
    reset_n = 1'b1;
    tstep(1, 2);
    chk("restart_addr", int'(bus.rom_addr), 64);
    wait_new(1, 2, "restart_note", n);
    chk("restart_latency", n, 2);

    // Randomized run: random beat spacing, pauses and song changes.
    bcnt = 2; p = 1; rs = 2;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 99) < 3) p = !p;
      if ($urandom_range(0, 299) == 0) rs = 2'($urandom);
      step(p, rs, bcnt == 0);
      bcnt = (bcnt == 0) ? $urandom_range(3, 6) : bcnt - 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller for the 128x12 song ROM. Each ROM entry is {note[5:0], duration[5:0]}. The ROM has one cycle of registered read latency.
- The ROM is split into 4 songs of 32 entries. Address = {song[1:0], idx[4:0]}.
- The block walks the selected song entry by entry and presents each note to the note player with a one-cycle new_note strobe.
- It holds each note for `duration` beats, counted on the beat-generator tick. It supports pause, song change and end-of-song detection.

Parameters:
- SONG_BITS, 2, song select width (number of songs = 2^SONG_BITS)
- IDX_BITS, 5, entry index width within a song (entries per song = 2^IDX_BITS)
- NOTE_W, 6, note field width (ROM dout upper field)
- DUR_W, 6, duration field width (ROM dout lower field, in beats)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- play  in  1  level; 1 = run/continue, 0 = pause
- song  in  SONG_BITS  song select
- beat  in  1  one-cycle tick from beat generator
- rom_addr  out  SONG_BITS+IDX_BITS  registered ROM address
- rom_dout  in  NOTE_W+DUR_W  ROM data, valid the cycle after the ROM samples rom_addr
- note  out  NOTE_W  current note (0 = rest)
- duration  out  DUR_W  current note's duration
- new_note  out  1  one-cycle strobe when note/duration update
- playing  out  1  high in all states except IDLE
- song_done  out  1  one-cycle strobe at end of song

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, idx=0, song_q=0, beat_cnt=0. All outputs are 0 (rom_addr, note, duration, new_note, playing, song_done).
- States:
  - IDLE -> FETCH when play=1. song_q<=song, idx<=0, rom_addr<={song,0}.
  - FETCH -> WAIT unconditionally (ROM samples rom_addr on this edge).
  - WAIT: rom_dout is valid.
    - If dout[DUR_W-1:0]==0 (end marker): song_done=1 for one cycle, then IDLE. idx<=0. note/duration hold their last values. No new_note.
    - Otherwise: note<=dout[upper], duration<=dout[lower], beat_cnt<=dout[lower], new_note=1 for one cycle, then PLAY.
  - PLAY:
    - If beat=1 and play=1: when beat_cnt>1, beat_cnt decrements. When beat_cnt==1, the note ends:
      - idx==2^IDX_BITS-1: song_done=1, then IDLE, idx<=0 (no wrap into the next song).
      - Otherwise: idx<=idx+1, rom_addr<={song_q,idx+1}, then FETCH.
    - A beat in the new_note cycle counts.
- Latency:
  - Edge E0 samples play=1 in IDLE; new_note is high in the cycle after edge E2.
  - Between notes: the final-beat edge B0 leads to new_note high after B2.
- Beats arriving in FETCH/WAIT are dropped. The beat period is always more than 3 clk cycles.
- Pause:
  - play=0 in PLAY freezes beat_cnt, note and duration. playing stays 1.
  - play=0 in FETCH/WAIT does not abort the fetch; the entry is issued, then the block waits in PLAY.
  - play=0 in IDLE stays IDLE.
- Song change: if song!=song_q in any non-IDLE state, the next edge does song_q<=song, idx<=0, rom_addr<={song,0}, state FETCH. No song_done.
  - This has priority over beat completion and the WAIT decode in the same cycle; that new_note and song_done are suppressed.
- Rest entries (note=0, duration>0) are issued like any note.
- new_note and song_done are never high in the same cycle.
- rom_addr is registered and changes only on the IDLE->FETCH, PLAY->FETCH and song-change transitions.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). After release, the block restarts from IDLE.

Test Plan:
- ROM model, song 0 entry 0 = {49,12}, entry 1 = {1,8}. play=1, song=0:
  - rom_addr=0.
  - new_note 2 edges after the play sample, with note=49, duration=12.
  - After 12 beats, rom_addr=1, then new_note with note=1, duration=8.
- Entry {0,0} at song 0 idx 3 -> after entry 2 completes: song_done pulse, playing=0, no new_note, rom_addr stays 3.
- Pause mid-note: after 4 of 12 beats drop play for 5 beats -> beat_cnt stays 8. Resume -> next fetch occurs exactly 8 further beats later.
- Song change from 0 to 2 during PLAY, in the same cycle as the final beat -> rom_addr=64, no song_done, no idx advance, new_note from entry 64.
- Song 1 with 32 nonzero entries -> after idx 31 completes: song_done, IDLE, rom_addr never reaches 64.
- Assert reset_n=0 mid-PLAY (asynchronously, between edges) -> all outputs 0 immediately. Release with play=1 -> restarts at {song,0}.
